// File: rtl/cnna_mem_pkg.sv
// Shared constants and helpers for the cnna buffer memories (ibuf/wbuf/obuf).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cnna_mem_pkg;

    localparam int RD_LAT_MAX = 3;

    localparam string MEM_STYLE_BLOCK = "block";
    localparam string MEM_STYLE_DIST  = "distributed";

    function automatic int clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res++;
            v = v >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_arb.sv
// Round-robin arbiter: grants the first requester at or after the rotating pointer.
// Latency: grant is combinational from req/ptr; pointer advances on the clock edge.
// Backpressure: en low suppresses all grants and freezes the pointer.
module rr_arb
    import cnna_mem_pkg::*;
#(
    parameter int CH = 2,
    parameter int IW = (CH > 1) ? clog2(CH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CH-1:0] req,
    input  logic          en,
    output logic [CH-1:0] gnt,
    output logic [IW-1:0] gnt_idx
);

    localparam logic [IW-1:0] LAST = IW'(CH - 1);

    logic [IW-1:0] ptr;

    // search ptr, ptr+1, ... (mod CH) and grant the first requester found
    always_comb begin
        int k;
        gnt     = '0;
        gnt_idx = '0;
        k       = 0;
        for (int i = 0; i < CH; i++) begin
            k = int'(ptr) + i;
            if (k >= CH) begin
                k = k - CH;
            end
            if (en && (gnt == '0) && req[IW'(k)]) begin
                gnt[IW'(k)] = 1'b1;
                gnt_idx     = IW'(k);
            end
        end
    end

    // pointer moves just past the winner so it waits behind the others next time
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (|gnt) begin
            ptr <= (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/spram_arb.sv
// Multi-channel single-port RAM with round-robin access arbitration (optional SPRAM_ARB_CLR_EN clear).
// Latency: read data and channel tag appear RD_LAT cycles after the grant; writes are silent.
// Backpressure: requesters hold req until gnt; O_busy (post-reset clear) blocks all grants.
module spram_arb
    import cnna_mem_pkg::*;
#(
    parameter string MEM_STYLE = MEM_STYLE_BLOCK,
    parameter int    ASIZE     = 10,
    parameter int    DSIZE     = 32,
    parameter int    CH        = 2,
    parameter int    RD_LAT    = 1
) (
    input  logic                  I_clk,
    input  logic                  I_rst,
    input  logic [CH-1:0]         I_req,
    input  logic [CH-1:0]         I_wr,
    input  logic [CH*ASIZE-1:0]   I_addr,
    input  logic [CH*DSIZE-1:0]   I_data,
    input  logic [CH*DSIZE/8-1:0] I_be,
    output logic [CH-1:0]         O_gnt,
    output logic [CH-1:0]         O_rvld,
    output logic [DSIZE-1:0]      O_data,
    output logic                  O_busy
);

    localparam int DEPTH = 1 << ASIZE;
    localparam int NB    = DSIZE / 8;
    localparam int IW    = (CH > 1) ? clog2(CH) : 1;
    localparam int LAT   = (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : ((RD_LAT < 1) ? 1 : RD_LAT);

    logic [ASIZE-1:0] addr_a [CH];
    logic [DSIZE-1:0] data_a [CH];
    logic [NB-1:0]    be_a   [CH];

    logic [CH-1:0]    gnt;
    logic [IW-1:0]    gnt_idx;
    logic             gnt_any;
    logic             rd_gnt;
    logic             busy;
    logic             clr_we;
    logic [ASIZE-1:0] clr_addr;

    logic             mem_we;
    logic [ASIZE-1:0] mem_addr;
    logic [DSIZE-1:0] mem_wdat;
    logic [NB-1:0]    mem_wbe;
    logic [DSIZE-1:0] mem_rdat;

    logic [DSIZE-1:0] dat_q [LAT];
    logic [CH-1:0]    tag_q [LAT];

    for (genvar k = 0; k < CH; k++) begin : g_unpack
        assign addr_a[k] = I_addr[k*ASIZE +: ASIZE];
        assign data_a[k] = I_data[k*DSIZE +: DSIZE];
        assign be_a[k]   = I_be[k*NB +: NB];
    end

    rr_arb #(.CH(CH), .IW(IW)) u_arb (
        .clk     (I_clk),
        .rst     (I_rst),
        .req     (I_req),
        .en      (~busy & ~I_rst),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign gnt_any = |gnt;
    assign rd_gnt  = gnt_any & ~I_wr[gnt_idx];

`ifdef SPRAM_ARB_CLR_EN
    logic busy_q;

    // after every reset sweep zeros over the whole array; restart from 0 if reset returns
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            busy_q   <= 1'b1;
            clr_addr <= '0;
        end else if (busy_q) begin
            clr_addr <= clr_addr + 1'b1;
            if (clr_addr == '1) begin
                busy_q <= 1'b0;
            end
        end
    end

    assign busy   = busy_q;
    assign clr_we = busy_q & ~I_rst;
`else
    assign busy     = 1'b0;
    assign clr_we   = 1'b0;
    assign clr_addr = '0;
`endif

    // the single array port serves the clear sweep first, otherwise the granted channel
    always_comb begin
        mem_we   = 1'b0;
        mem_addr = addr_a[gnt_idx];
        mem_wdat = data_a[gnt_idx];
        mem_wbe  = be_a[gnt_idx];
        if (clr_we) begin
            mem_we   = 1'b1;
            mem_addr = clr_addr;
            mem_wdat = '0;
            mem_wbe  = '1;
        end else begin
            mem_we = gnt_any & I_wr[gnt_idx];
        end
    end

    if (MEM_STYLE == MEM_STYLE_DIST) begin : g_dist
        (* ram_style = "distributed" *) logic [DSIZE-1:0] mem [DEPTH];

        // byte-lane write; unselected lanes keep their old contents
        always_ff @(posedge I_clk) begin
            if (mem_we) begin
                for (int b = 0; b < NB; b++) begin
                    if (mem_wbe[b]) mem[mem_addr][b*8 +: 8] <= mem_wdat[b*8 +: 8];
                end
            end
        end

        assign mem_rdat = mem[mem_addr];
    end else begin : g_block
        (* ram_style = "block" *) logic [DSIZE-1:0] mem [DEPTH];

        // byte-lane write; unselected lanes keep their old contents
        always_ff @(posedge I_clk) begin
            if (mem_we) begin
                for (int b = 0; b < NB; b++) begin
                    if (mem_wbe[b]) mem[mem_addr][b*8 +: 8] <= mem_wdat[b*8 +: 8];
                end
            end
        end

        assign mem_rdat = mem[mem_addr];
    end

    // read pipeline: stage 0 samples the array (old contents), later stages move only
    // with valid data so O_data holds its last value between reads
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            for (int i = 0; i < LAT; i++) begin
                dat_q[i] <= '0;
                tag_q[i] <= '0;
            end
        end else begin
            tag_q[0] <= rd_gnt ? gnt : '0;
            if (rd_gnt) dat_q[0] <= mem_rdat;
            for (int i = 1; i < LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
                if (|tag_q[i-1]) dat_q[i] <= dat_q[i-1];
            end
        end
    end

    assign O_gnt  = gnt;
    assign O_rvld = tag_q[LAT-1];
    assign O_data = dat_q[LAT-1];
    assign O_busy = busy;

endmodule
